// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM for the MIPS-subset datapath: sequences IF/ID/EXE/MEM/WB,
// with a data-memory ready handshake and timeout, sticky HALT, illegal-opcode trap and retire counter.
module mc_control_fsm #(
    parameter bit MEM_WAIT_EN  = 1'b1,
    parameter int WAIT_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       Op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWre,
    output logic             IRWre,
    output logic             InsMemRW,
    output logic             ExtSel,
    output logic             RegWre,
    output logic             WrRegDSrc,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic             DBDataSrc,
    output logic [1:0]       RegDst,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ALUOp,
    output logic             RD,
    output logic             WR,
    output logic [3:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic             mem_fault,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_LS = 4'd2,
        S_MEM    = 4'd3,
        S_WB_LD  = 4'd4,
        S_EXE_BR = 4'd5,
        S_EXE_AL = 4'd6,
        S_WB_AL  = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SLTU = 6'b100111;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLTU = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_AND  = 3'b110;

    // Wide enough to hold WAIT_TIMEOUT itself; the timeout fires on the cycle
    // whose increment would bring the count up to WAIT_TIMEOUT.
    localparam int WCW = $clog2(WAIT_TIMEOUT + 2);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

    state_t           state_q;
    state_t           state_d;
    logic [WCW-1:0]   wait_cnt;
    logic             is_alu;
    logic             is_ls;
    logic             is_br;
    logic             is_jmp;
    logic             is_halt;
    logic             is_legal;
    logic [2:0]       alu_code;
    logic             mem_done;
    logic             timeout_hit;
    logic             drive_dp;
    logic             alu_hold;

    always_comb begin
        is_alu   = 1'b0;
        is_ls    = 1'b0;
        is_br    = 1'b0;
        is_jmp   = 1'b0;
        is_halt  = 1'b0;
        alu_code = ALU_ADD;
        case (Op)
            OP_ADD, OP_ADDI: begin is_alu = 1'b1; alu_code = ALU_ADD;  end
            OP_SUB:          begin is_alu = 1'b1; alu_code = ALU_SUB;  end
            OP_OR, OP_ORI:   begin is_alu = 1'b1; alu_code = ALU_OR;   end
            OP_AND:          begin is_alu = 1'b1; alu_code = ALU_AND;  end
            OP_SLL:          begin is_alu = 1'b1; alu_code = ALU_SLL;  end
            OP_SLT:          begin is_alu = 1'b1; alu_code = ALU_SLT;  end
            OP_SLTU:         begin is_alu = 1'b1; alu_code = ALU_SLTU; end
            OP_SW, OP_LW:    begin is_ls  = 1'b1; alu_code = ALU_ADD;  end
            OP_BEQ, OP_BNE:  begin is_br  = 1'b1; alu_code = ALU_SUB;  end
            OP_J, OP_JR, OP_JAL: is_jmp  = 1'b1;
            OP_HALT:             is_halt = 1'b1;
            default: ;
        endcase
    end

    assign is_legal = is_alu | is_ls | is_br | is_jmp | is_halt;

    // Memory handshake: in MEM the access is complete on any cycle where
    // mem_ready=1; mem_ready is ignored in every other state, and entirely
    // when MEM_WAIT_EN=0 (MEM then lasts exactly one cycle).
    assign mem_done    = !MEM_WAIT_EN || mem_ready;
    assign timeout_hit = (WAIT_TIMEOUT != 0) && (state_q == S_MEM) && !mem_done
                         && (wait_cnt == WAIT_LAST);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= S_IF;
            wait_cnt  <= '0;
            instr_cnt <= '0;
            illegal   <= 1'b0;
            mem_fault <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_EXE_LS) begin
                wait_cnt <= '0;
            end else if (state_q == S_MEM && !mem_done) begin
                wait_cnt <= wait_cnt + WCW'(1);
            end
            if (PCWre) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
            if (state_q == S_ID && !is_legal) begin
                illegal <= 1'b1;
            end
            if (timeout_hit) begin
                mem_fault <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        RegWre    = 1'b0;
        WrRegDSrc = 1'b0;
        DBDataSrc = 1'b0;
        RegDst    = 2'b00;
        PCSrc     = 2'b00;
        RD        = 1'b1;
        WR        = 1'b1;
        case (state_q)
            S_IF: begin
                IRWre    = 1'b1;
                InsMemRW = 1'b1;
                state_d  = S_ID;
            end
            S_ID: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_ls) begin
                    state_d = S_EXE_LS;
                end else if (is_br) begin
                    state_d = S_EXE_BR;
                end else if (is_alu) begin
                    state_d = S_EXE_AL;
                end else begin
                    // Jumps and undefined opcodes retire here; undefined ones fall through to PC+4.
                    state_d = S_IF;
                    PCWre   = 1'b1;
                    if (Op == OP_J || Op == OP_JAL) begin
                        PCSrc = 2'b11;
                    end else if (Op == OP_JR) begin
                        PCSrc = 2'b10;
                    end
                    if (Op == OP_JAL) begin
                        RegWre    = 1'b1;
                        RegDst    = 2'b00;
                        WrRegDSrc = 1'b0;
                    end
                end
            end
            S_EXE_LS: state_d = S_MEM;
            S_MEM: begin
                RD = (Op != OP_LW);
                WR = (Op != OP_SW);
                if (mem_done) begin
                    if (Op == OP_LW) begin
                        state_d = S_WB_LD;
                    end else begin
                        state_d = S_IF;
                        PCWre   = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                end
            end
            S_WB_LD: begin
                RegWre    = 1'b1;
                RegDst    = 2'b01;
                WrRegDSrc = 1'b1;
                DBDataSrc = 1'b1;
                PCWre     = 1'b1;
                state_d   = S_IF;
            end
            S_EXE_BR: begin
                PCWre = 1'b1;
                if ((Op == OP_BEQ && zero) || (Op == OP_BNE && !zero)) begin
                    PCSrc = 2'b01;
                end
                state_d = S_IF;
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL: begin
                RegWre    = 1'b1;
                WrRegDSrc = 1'b1;
                RegDst    = (Op == OP_ADDI || Op == OP_ORI) ? 2'b01 : 2'b10;
                PCWre     = 1'b1;
                state_d   = S_IF;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Operand-path selects follow the decoded Op from ID to writeback; the ALU
    // code only from execute onward.
    assign drive_dp = (state_q != S_IF) && (state_q != S_HALT);
    assign alu_hold = drive_dp && (state_q != S_ID);
    assign ExtSel   = drive_dp && !(Op == OP_ORI || Op == OP_SLL);
    assign ALUSrcA  = drive_dp && (Op == OP_SLL);
    assign ALUSrcB  = drive_dp && (Op == OP_ADDI || Op == OP_ORI || Op == OP_LW || Op == OP_SW);
    assign ALUOp    = alu_hold ? alu_code : ALU_ADD;

    assign state  = state_q;
    assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed vector table, hand-written corner sequences and
// random instruction streams checked against a per-instruction cycle model.
module tb_mc_control_fsm;

    localparam int TO = 4;
    localparam int CW = 4;

    localparam logic [5:0] ADD  = 6'b000000, SUB  = 6'b000001, ADDI = 6'b000010;
    localparam logic [5:0] OR_  = 6'b010000, AND_ = 6'b010001, ORI  = 6'b010010;
    localparam logic [5:0] SLL  = 6'b011000, SLT  = 6'b100110, SLTU = 6'b100111;
    localparam logic [5:0] SW   = 6'b110000, LW   = 6'b110001, BEQ  = 6'b110100;
    localparam logic [5:0] BNE  = 6'b110101, J    = 6'b111000, JR   = 6'b111001;
    localparam logic [5:0] JAL  = 6'b111010, HLT  = 6'b111111;

    localparam int C_ALU = 0, C_LS = 1, C_BR = 2, C_JMP = 3, C_HALT = 4, C_ILL = 5;

    logic          CLK;
    logic          RST;
    logic [5:0]    Op;
    logic          zero;
    logic          mem_ready;
    logic          PCWre, IRWre, InsMemRW, ExtSel, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB, DBDataSrc;
    logic [1:0]    RegDst, PCSrc;
    logic [2:0]    ALUOp;
    logic          RD, WR;
    logic [3:0]    state;
    logic          halted, illegal, mem_fault;
    logic [CW-1:0] instr_cnt;

    mc_control_fsm #(.MEM_WAIT_EN(1'b1), .WAIT_TIMEOUT(TO), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .Op(Op), .zero(zero), .mem_ready(mem_ready),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ExtSel(ExtSel), .RegWre(RegWre),
        .WrRegDSrc(WrRegDSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc),
        .RegDst(RegDst), .PCSrc(PCSrc), .ALUOp(ALUOp), .RD(RD), .WR(WR), .state(state),
        .halted(halted), .illegal(illegal), .mem_fault(mem_fault), .instr_cnt(instr_cnt)
    );

    // clock / reset block
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [3:0] st;
        logic pcw, irw, imrw, ext, rw, wrs, srca, srcb, dbs;
        logic [1:0] rdst, pcs;
        logic [2:0] aop;
        logic rd, wr, hlt;
    } ctl_t;

    typedef struct packed {
        logic z, r, set_ill, set_flt;
        ctl_t c;
    } cyc_t;

    typedef struct packed {
        logic [5:0] op;
        logic z, r;
        logic [3:0] st;
        logic pcw;
        logic [1:0] pcs;
        logic rw;
        logic [1:0] rdst;
        logic rd, wr, dbs;
    } tvec_t;

    ctl_t  act;
    cyc_t  exp_q[$];
    tvec_t tv[$];
    int    total = 0;
    int    bad   = 0;
    int    m_cnt = 0;
    logic  m_ill = 1'b0;
    logic  m_flt = 1'b0;
    logic [5:0] legal_ops [16];

    assign act = {state, PCWre, IRWre, InsMemRW, ExtSel, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB,
                  DBDataSrc, RegDst, PCSrc, ALUOp, RD, WR, halted};

    // reference model: instruction classes and control values from the ISA rules
    function automatic int cls_of(input logic [5:0] op);
        if (op inside {ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT, SLTU}) return C_ALU;
        if (op inside {SW, LW}) return C_LS;
        if (op inside {BEQ, BNE}) return C_BR;
        if (op inside {J, JR, JAL}) return C_JMP;
        if (op == HLT) return C_HALT;
        return C_ILL;
    endfunction

    function automatic logic [2:0] aop_of(input logic [5:0] op);
        if (op inside {SUB, BEQ, BNE}) return 3'b001;
        if (op == SLTU) return 3'b010;
        if (op == SLT) return 3'b011;
        if (op == SLL) return 3'b100;
        if (op inside {OR_, ORI}) return 3'b101;
        if (op == AND_) return 3'b110;
        return 3'b000;
    endfunction

    function automatic ctl_t dflt();
        ctl_t c = '0;
        c.rd = 1'b1;
        c.wr = 1'b1;
        return c;
    endfunction

    function automatic ctl_t if_ctl();
        ctl_t c = dflt();
        c.irw  = 1'b1;
        c.imrw = 1'b1;
        return c;
    endfunction

    function automatic ctl_t halt_ctl();
        ctl_t c = dflt();
        c.st  = 4'd8;
        c.hlt = 1'b1;
        return c;
    endfunction

    function automatic ctl_t base(input logic [5:0] op);
        ctl_t c = dflt();
        c.ext  = !(op == ORI || op == SLL);
        c.srca = (op == SLL);
        c.srcb = (op inside {ADDI, ORI, LW, SW});
        return c;
    endfunction

    function automatic logic rb();
        return $urandom_range(0, 1) != 0;
    endfunction

    function automatic tvec_t mk(input logic [5:0] op, input logic z, input logic r,
                                 input logic [3:0] st, input logic pcw, input logic [1:0] pcs,
                                 input logic rw, input logic [1:0] rdst, input logic rd,
                                 input logic wr, input logic dbs);
        tvec_t v;
        v.op = op; v.z = z; v.r = r; v.st = st; v.pcw = pcw; v.pcs = pcs;
        v.rw = rw; v.rdst = rdst; v.rd = rd; v.wr = wr; v.dbs = dbs;
        return v;
    endfunction

    // scoreboard helpers
    task automatic chk_ctl(input string name, input ctl_t e);
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s: ctl got %h required %h (state %0d) at %0t", name, act, e, state, $time);
        end
    endtask

    task automatic chk_status(input string name);
        logic [CW-1:0] ec;
        ec = m_cnt[CW-1:0];
        total++;
        if ({instr_cnt, illegal, mem_fault} !== {ec, m_ill, m_flt}) begin
            bad++;
            $display("FAIL %s: cnt/ill/flt got %0d/%b/%b required %0d/%b/%b at %0t",
                     name, instr_cnt, illegal, mem_fault, ec, m_ill, m_flt, $time);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h at %0t", name, got, req, $time);
        end
    endtask

    task automatic push(input logic z, input logic r, input ctl_t c, input logic si, input logic sf);
        cyc_t y;
        y.z = z; y.r = r; y.set_ill = si; y.set_flt = sf; y.c = c;
        exp_q.push_back(y);
    endtask

    // driver: expands one instruction into its expected per-cycle control trace
    task automatic gen_instr(input logic [5:0] op, input int w, input int n_halt, output bit stops);
        int   cls;
        ctl_t c, d, e, m;
        logic z;
        cls   = cls_of(op);
        c     = base(op);
        stops = 1'b0;
        Op    = op;
        push(rb(), rb(), if_ctl(), 1'b0, 1'b0);
        d    = c;
        d.st = 4'd1;
        case (cls)
            C_JMP: begin
                d.pcw = 1'b1;
                d.pcs = (op == JR) ? 2'b10 : 2'b11;
                if (op == JAL) begin d.rw = 1'b1; d.rdst = 2'b00; d.wrs = 1'b0; end
                push(rb(), rb(), d, 1'b0, 1'b0);
            end
            C_ILL: begin
                d.pcw = 1'b1;
                push(rb(), rb(), d, 1'b1, 1'b0);
            end
            C_HALT: begin
                push(rb(), rb(), d, 1'b0, 1'b0);
                for (int i = 0; i < n_halt; i++) push(rb(), rb(), halt_ctl(), 1'b0, 1'b0);
                stops = 1'b1;
            end
            C_ALU: begin
                push(rb(), rb(), d, 1'b0, 1'b0);
                e = c; e.st = 4'd6; e.aop = aop_of(op);
                push(rb(), rb(), e, 1'b0, 1'b0);
                e.st = 4'd7; e.rw = 1'b1; e.wrs = 1'b1; e.pcw = 1'b1;
                e.rdst = (op == ADDI || op == ORI) ? 2'b01 : 2'b10;
                push(rb(), rb(), e, 1'b0, 1'b0);
            end
            C_BR: begin
                push(rb(), rb(), d, 1'b0, 1'b0);
                z = rb();
                e = c; e.st = 4'd5; e.aop = 3'b001; e.pcw = 1'b1;
                e.pcs = ((op == BEQ && z) || (op == BNE && !z)) ? 2'b01 : 2'b00;
                push(z, rb(), e, 1'b0, 1'b0);
            end
            default: begin
                push(rb(), rb(), d, 1'b0, 1'b0);
                e = c; e.st = 4'd2; e.aop = 3'b000;
                push(rb(), rb(), e, 1'b0, 1'b0);
                for (int k = 0; k < TO; k++) begin
                    m = e; m.st = 4'd3;
                    if (op == LW) m.rd = 1'b0; else m.wr = 1'b0;
                    if (k >= w) begin
                        if (op == SW) m.pcw = 1'b1;
                        push(rb(), 1'b1, m, 1'b0, 1'b0);
                        if (op == LW) begin
                            m = e; m.st = 4'd4; m.rw = 1'b1; m.rdst = 2'b01;
                            m.wrs = 1'b1; m.dbs = 1'b1; m.pcw = 1'b1;
                            push(rb(), rb(), m, 1'b0, 1'b0);
                        end
                        break;
                    end else if (k == TO - 1) begin
                        push(rb(), 1'b0, m, 1'b0, 1'b1);
                        for (int i = 0; i < n_halt; i++) push(rb(), rb(), halt_ctl(), 1'b0, 1'b0);
                        stops = 1'b1;
                    end else begin
                        push(rb(), 1'b0, m, 1'b0, 1'b0);
                    end
                end
            end
        endcase
    endtask

    task automatic run_q(input string name, input int max_n);
        cyc_t y;
        int   n = 0;
        while (exp_q.size() > 0 && n < max_n) begin
            y = exp_q.pop_front();
            zero = y.z;
            mem_ready = y.r;
            #1;
            chk_ctl(name, y.c);
            chk_status(name);
            if (y.c.pcw) m_cnt = (m_cnt + 1) % (1 << CW);
            if (y.set_ill) m_ill = 1'b1;
            if (y.set_flt) m_flt = 1'b1;
            @(posedge CLK);
            #1;
            n++;
        end
        exp_q.delete();
    endtask

    task automatic do_reset(input string name);
        RST = 1'b0;
        zero = rb();
        mem_ready = rb();
        @(posedge CLK);
        #1;
        m_cnt = 0; m_ill = 1'b0; m_flt = 1'b0;
        chk_ctl(name, if_ctl());
        chk_status(name);
        @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    initial begin
        bit   stops;
        logic [5:0] op;
        logic [12:0] got_v, req_v;
        int   w;

        RST = 1'b0; Op = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        legal_ops = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT, SLTU, SW, LW, BEQ, BNE, J, JR, JAL};

        // directed vector table: op, zero, ready, state, PCWre, PCSrc, RegWre, RegDst, RD, WR, DBDataSrc
        tv.push_back(mk(ADD, 0, 1, 0, 0, 2'b00, 0, 2'b00, 1, 1, 0));
        tv.push_back(mk(ADD, 0, 1, 1, 0, 2'b00, 0, 2'b00, 1, 1, 0));
        tv.push_back(mk(ADD, 0, 1, 6, 0, 2'b00, 0, 2'b00, 1, 1, 0));
        tv.push_back(mk(ADD, 0, 1, 7, 1, 2'b00, 1, 2'b10, 1, 1, 0));
        tv.push_back(mk(BEQ, 1, 0, 0, 0, 2'b00, 0, 2'b00, 1, 1, 0));
        tv.push_back(mk(BEQ, 1, 0, 1, 0, 2'b00, 0, 2'b00, 1, 1, 0));
        tv.push_back(mk(BEQ, 1, 0, 5, 1, 2'b01, 0, 2'b00, 1, 1, 0));
        tv.push_back(mk(BNE, 1, 0, 0, 0, 2'b00, 0, 2'b00, 1, 1, 0));
        tv.push_back(mk(BNE, 1, 0, 1, 0, 2'b00, 0, 2'b00, 1, 1, 0));
        tv.push_back(mk(BNE, 1, 0, 5, 1, 2'b00, 0, 2'b00, 1, 1, 0));
        tv.push_back(mk(JAL, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 1, 0));
        tv.push_back(mk(JAL, 0, 0, 1, 1, 2'b11, 1, 2'b00, 1, 1, 0));
        tv.push_back(mk(6'b101010, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 1, 0));
        tv.push_back(mk(6'b101010, 0, 0, 1, 1, 2'b00, 0, 2'b00, 1, 1, 0));
        tv.push_back(mk(LW, 0, 1, 0, 0, 2'b00, 0, 2'b00, 1, 1, 0));
        tv.push_back(mk(LW, 0, 1, 1, 0, 2'b00, 0, 2'b00, 1, 1, 0));
        tv.push_back(mk(LW, 0, 1, 2, 0, 2'b00, 0, 2'b00, 1, 1, 0));
        tv.push_back(mk(LW, 0, 0, 3, 0, 2'b00, 0, 2'b00, 0, 1, 0));
        tv.push_back(mk(LW, 0, 0, 3, 0, 2'b00, 0, 2'b00, 0, 1, 0));
        tv.push_back(mk(LW, 0, 0, 3, 0, 2'b00, 0, 2'b00, 0, 1, 0));
        tv.push_back(mk(LW, 0, 1, 3, 0, 2'b00, 0, 2'b00, 0, 1, 0));
        tv.push_back(mk(LW, 0, 1, 4, 1, 2'b00, 1, 2'b01, 1, 1, 1));
        tv.push_back(mk(SW, 0, 1, 0, 0, 2'b00, 0, 2'b00, 1, 1, 0));
        tv.push_back(mk(SW, 0, 1, 1, 0, 2'b00, 0, 2'b00, 1, 1, 0));
        tv.push_back(mk(SW, 0, 1, 2, 0, 2'b00, 0, 2'b00, 1, 1, 0));
        tv.push_back(mk(SW, 0, 1, 3, 1, 2'b00, 0, 2'b00, 1, 0, 0));

        do_reset("reset0");

        foreach (tv[i]) begin
            Op = tv[i].op;
            zero = tv[i].z;
            mem_ready = tv[i].r;
            #1;
            got_v = {state, PCWre, PCSrc, RegWre, RegDst, RD, WR, DBDataSrc};
            req_v = {tv[i].st, tv[i].pcw, tv[i].pcs, tv[i].rw, tv[i].rdst, tv[i].rd, tv[i].wr, tv[i].dbs};
            total++;
            if (got_v !== req_v) begin
                bad++;
                $display("FAIL vec%0d: got %h required %h", i, got_v, req_v);
            end
            @(posedge CLK);
            #1;
        end
        chk_val("vec_cnt", 32'(instr_cnt), 32'd7);
        chk_val("vec_ill", 32'(illegal), 32'd1);

        // sw with mem_ready stuck low: timeout, fault, HALT; then reset from HALT
        do_reset("reset1");
        gen_instr(SW, 100, 3, stops);
        run_q("sw_timeout", 1000);
        chk_val("halt_after_fault", {28'd0, state}, 32'd8);
        chk_val("fault_flags", {29'd0, halted, mem_fault, illegal}, 32'b110);
        do_reset("reset_halt");

        // halt opcode: 20 cycles in HALT with the counter frozen
        gen_instr(J, 0, 0, stops);
        run_q("j_pre", 1000);
        gen_instr(HLT, 0, 20, stops);
        run_q("halt_hold", 1000);
        chk_val("halt_cnt", 32'(instr_cnt), 32'd1);
        do_reset("reset_halt2");

        // reset arriving while waiting in MEM
        gen_instr(LW, 3, 0, stops);
        run_q("lw_mid", 4);
        do_reset("reset_mem");

        // retire counter wraps at 2^CW
        for (int i = 0; i < 18; i++) begin
            gen_instr(J, 0, 0, stops);
            run_q("wrap", 1000);
        end
        chk_val("wrap_cnt", 32'(instr_cnt), 32'd2);

        // randomized instruction stream
        do_reset("reset_rand");
        for (int n = 0; n < 250; n++) begin
            w = $urandom_range(0, 99);
            if (w < 2) begin
                op = HLT;
            end else if (w < 10) begin
                do op = 6'($urandom_range(0, 63)); while (cls_of(op) != C_ILL);
            end else begin
                op = legal_ops[$urandom_range(0, 15)];
            end
            w = ($urandom_range(0, 19) == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, TO - 1);
            gen_instr(op, w, $urandom_range(1, 3), stops);
            run_q("rand", 1000);
            if (stops) do_reset("rand_reset");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Parametrised multi-cycle control FSM for the MIPS-subset CPU datapath. It sequences each instruction through IF/ID/EXE/MEM/WB and drives every datapath control line as a clean 0/1 level; no line ever floats. Over the first-generation control unit it adds a data-memory ready handshake with a timeout, a sticky HALT state, an illegal-opcode trap and a retired-instruction counter. It sits between the instruction register (Op), the ALU (zero) and the datapath muxes and enables.

## Interface
- MEM_WAIT_EN, 1, 1 = MEM state waits for mem_ready; 0 = mem_ready ignored, MEM lasts one cycle
- WAIT_TIMEOUT, 16, max cycles spent in MEM before a timeout fault; 0 disables the timeout
- CNT_W, 32, width of instr_cnt
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset, synchronous, active-low
- Op  in  6  opcode from the IR; stable from the end of IF
- zero  in  1  ALU zero flag
- mem_ready  in  1  data memory has completed the access
- PCWre, IRWre, InsMemRW, ExtSel, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB, DBDataSrc  out  1 each  datapath controls
- RegDst  out  2  register destination select: 00 = $31, 01 = rt, 10 = rd
- PCSrc  out  2  next-PC select: 00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump target
- ALUOp  out  3  ALU operation: add 000, sub 001, sltu 010, slt 011, sll 100, or 101, and 110
- RD, WR  out  1 each  data memory read/write strobes, active-low
- state  out  4  current FSM state
- halted, illegal, mem_fault  out  1 each  status flags
- instr_cnt  out  CNT_W  count of retired instructions

## Operation
- States: IF=0000, ID=0001, EXE_LS=0010, MEM=0011, WB_LD=0100, EXE_BR=0101, EXE_AL=0110, WB_AL=0111, HALT=1000.
- Transitions out of IF: IF always goes to ID.
- Transitions out of ID:
  - j, jr, jal, and any undefined Op go to IF.
  - halt (111111) goes to HALT.
  - sw (110000) and lw (110001) go to EXE_LS.
  - beq (110100) and bne (110101) go to EXE_BR.
  - add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sltu 100111 go to EXE_AL.
- Transitions from the execute and memory states:
  - EXE_LS goes to MEM; EXE_BR goes to IF; EXE_AL goes to WB_AL.
  - MEM exits when mem_ready=1 (or immediately when MEM_WAIT_EN=0): sw goes to IF, lw goes to WB_LD.
  - WB_LD and WB_AL go to IF.
  - HALT holds until reset.
- Outputs are combinational from state, Op, zero and mem_ready. Defaults: all 1-bit controls 0, RD=WR=1, multi-bit controls 0.
- IF: IRWre=1, InsMemRW=1.
- PCWre=1 only in the commit cycle of each instruction:
  - ID for j, jr, jal and illegal Ops;
  - EXE_BR;
  - MEM on exit, for sw only;
  - WB_LD and WB_AL.
- PCSrc:
  - 11 for j and jal; 10 for jr.
  - 01 in EXE_BR when (beq and zero=1) or (bne and zero=0); otherwise 00.
- jal in ID: RegWre=1, RegDst=00, WrRegDSrc=0.
- ExtSel=0 for ori and sll; 1 for every other Op.
- ALUSrcB=1 for addi, ori, lw and sw. ALUSrcA=1 for sll.
- ALUOp:
  - add for lw, sw and addi; sub for beq and bne; or for ori.
  - Other ALU Ops use their own code.
  - Held through EXE_*, MEM and WB_*.
- MEM: RD=0 for lw, WR=0 for sw, for the whole stay in MEM.
- WB_LD: RegWre=1, RegDst=01, WrRegDSrc=1, DBDataSrc=1.
- WB_AL: RegWre=1, WrRegDSrc=1, DBDataSrc=0; RegDst=01 for addi and ori, 10 for all others.
- Wait counter:
  - Clears on MEM entry and increments each cycle spent in MEM without mem_ready.
  - When WAIT_TIMEOUT≠0 and the count reaches WAIT_TIMEOUT: mem_fault is set (sticky) and the next state is HALT. PCWre stays 0.
- illegal: sticky; set at ID on an undefined Op.
- halted: 1 in HALT. In HALT, InsMemRW=0 and all other controls are at their defaults.
- instr_cnt: increments on every cycle with PCWre=1 and wraps modulo 2^CNT_W.

## Timing
- Reset: on a rising edge with RST=0, state=IF, instr_cnt=0, and illegal, mem_fault and the wait counter clear.
  - Outputs during and right after reset are the IF values: IRWre=1, InsMemRW=1, all else default, halted=0.
- Reset wins over every transition, including when it arrives mid-MEM or in HALT.
- Latency in cycles, with mem_ready immediate:
  - j, jr, jal, illegal Ops: 2.
  - beq, bne: 3.
  - sw: 4.
  - ALU Ops: 4.
  - lw: 5.
  - Each wait cycle in MEM adds 1.
- mem_ready is sampled only in MEM. If mem_ready=1 in the same cycle the timeout is reached, it counts as success: no fault.
- zero is sampled only in EXE_BR.

## Test plan
- Reset then add (Op=000000), mem_ready=1: state sequence 0,1,6,7,0. PCWre=1 only in WB_AL, with RegDst=10 and RegWre=1. instr_cnt goes 0→1.
- lw with mem_ready low for 3 MEM cycles (WAIT_TIMEOUT=16): MEM lasts 4 cycles with RD=0 throughout. Then WB_LD with DBDataSrc=1. Total 8 cycles.
- beq with zero=1 → PCSrc=01 and PCWre=1 in EXE_BR. bne with zero=1 → PCSrc=00.
- jal: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0 in ID. Back in IF the next cycle.
- sw with mem_ready stuck at 0, WAIT_TIMEOUT=4: mem_fault=1, state=HALT, halted=1. Then RST=0 for one edge → state=IF and flags clear.
- Op=101010 (illegal): illegal=1 and PCWre=1 with PCSrc=00 in ID. halt Op → HALT held for 20 cycles with instr_cnt frozen.
